dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between the CPU memory stage and a DMA/loader engine.
- Grants at most one access per cycle and stalls the losing CPU request.
- Routes the one-cycle-latency read data back to whichever requester issued the read.
- Sits between the execute-stage address/store path and the DMem instance feeding load extension and writeback select.

Parameters:
- AWIDTH, 14, word-address width of DMem.
- DWIDTH, 32, data width.
- DMA_MAX_WAIT, 4, consecutive denied DMA cycles before DMA gets forced priority (1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- cpu_req  input  1  CPU access request this cycle.
- cpu_we  input  4  CPU byte write enables; 0 = read.
- cpu_addr  input  AWIDTH  CPU word address.
- cpu_din  input  DWIDTH  CPU store data, pre-shifted.
- cpu_stall  output  1  CPU request not granted this cycle; hold the pipeline.
- cpu_rvalid  output  1  CPU read data valid this cycle.
- cpu_dout  output  DWIDTH  CPU read data (raw word, before load extension).
- dma_req  input  1  DMA access request.
- dma_we  input  4  DMA byte write enables; 0 = read.
- dma_addr  input  AWIDTH  DMA word address.
- dma_din  input  DWIDTH  DMA write data.
- dma_gnt  output  1  DMA request accepted this cycle.
- dma_rvalid  output  1  DMA read data valid this cycle.
- dma_dout  output  DWIDTH  DMA read data.
- dmem_en  output  1  DMem enable.
- dmem_we  output  4  DMem byte write enables.
- dmem_addr  output  AWIDTH  DMem address.
- dmem_din  output  DWIDTH  DMem write data.
- dmem_dout  input  DWIDTH  DMem read data; valid the cycle after an enabled read.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Grant logic is combinational from requests and registered state.
- Default priority is CPU.
- Wait counter wait_cnt (4 bits):
  - Cleared when dma_req=0 or dma_gnt=1.
  - Increments when dma_req=1 and dma_gnt=0.
  - Saturates at DMA_MAX_WAIT.
- Grant rule:
  - DMA wins only if dma_req=1 and (cpu_req=0 or wait_cnt==DMA_MAX_WAIT). Otherwise CPU wins if cpu_req=1.
  - cpu_stall = cpu_req & ~cpu_grant.
  - dma_gnt = dma_grant.
- DMem drive:
  - dmem_en = cpu_grant | dma_grant.
  - dmem_we/addr/din are muxed from the winner.
  - With no winner: dmem_we=0, addr=0, din=0.
- Return tracking:
  - Registers rd_pend (granted access had we==0) and rd_owner (0=CPU, 1=DMA).
  - Next cycle: cpu_rvalid = rd_pend & ~rd_owner; dma_rvalid = rd_pend & rd_owner.
  - Writes never produce rvalid.
  - Read latency is exactly 1 cycle from grant; back-to-back reads from either side sustain one per cycle.
- Data hold:
  - When cpu_rvalid=1, cpu_dout = dmem_dout (bypass) and the value is captured into cpu_hold. Otherwise cpu_dout = cpu_hold.
  - dma_dout has the same structure with dma_hold.
  - Consequence: a DMA access in the cycle after a CPU read does not disturb cpu_dout.
- Simultaneous events:
  - CPU read granted in cycle N, DMA granted in N+1: cpu_rvalid in N+1 carries the CPU's data; dma_rvalid in N+2.
  - Same-address write by one side and read by the other in one cycle cannot occur (single grant).
- Reset:
  - While rst=1: grants forced 0; cpu_stall=0, dma_gnt=0, dmem_en=0, dmem_we=0, dmem_addr=0, dmem_din=0.
  - Also cleared: rd_pend, rd_owner, wait_cnt, cpu_hold, dma_hold, so cpu_rvalid=dma_rvalid=0 and cpu_dout=dma_dout=0.
  - Reset asserted in the cycle after a granted read suppresses that rvalid.
- Requests must hold stable while stalled/ungranted; the arbiter does not latch requests.

Test Plan:
- CPU only: cpu_req=1, we=0, addr=0x010 (mem[0x010]=0xDEADBEEF) -> dmem_en=1 same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_dout=0xDEADBEEF, held after rvalid drops.
- Contention: both request continuously, DMA_MAX_WAIT=4 -> CPU granted cycles 0-3 with dma_gnt=0; DMA granted cycle 4 with cpu_stall=1; wait_cnt clears; pattern repeats every 5 cycles.
- Interleave: CPU read 0x020 (=0x11112222) cycle N, DMA write 0x020 <- 0x33334444 (we=4'hF) cycle N+1 -> cpu_dout=0x11112222 in N+1 and stays; later CPU read returns 0x33334444.
- Byte write: CPU we=4'b0100, din=0x00AB0000 to word holding 0x12345678 -> readback 0x12AB5678; no rvalid on the write cycle+1.
- Reset mid-read: DMA read granted cycle N, rst=1 in N+1 -> dma_rvalid=0, dma_dout=0, dmem_en=0 in N+1; normal arbitration resumes the cycle after rst deasserts.
- Idle DMA: dma_req toggles 1,0,1 while cpu_req=1 -> wait_cnt never exceeds 1; DMA is never forced; cpu_stall stays 0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, DMA and DMem-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface dmem_arbiter_if #(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
);
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_din;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DWIDTH-1:0] cpu_dout;

    logic              dma_req;
    logic [3:0]        dma_we;
    logic [AWIDTH-1:0] dma_addr;
    logic [DWIDTH-1:0] dma_din;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DWIDTH-1:0] dma_dout;

    logic              dmem_en;
    logic [3:0]        dmem_we;
    logic [AWIDTH-1:0] dmem_addr;
    logic [DWIDTH-1:0] dmem_din;
    logic [DWIDTH-1:0] dmem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  dma_req, dma_we, dma_addr, dma_din,
        input  dmem_dout,
        output cpu_stall, cpu_rvalid, cpu_dout,
        output dma_gnt, dma_rvalid, dma_dout,
        output dmem_en, dmem_we, dmem_addr, dmem_din
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output dma_req, dma_we, dma_addr, dma_din,
        output dmem_dout,
        input  cpu_stall, cpu_rvalid, cpu_dout,
        input  dma_gnt, dma_rvalid, dma_dout,
        input  dmem_en, dmem_we, dmem_addr, dmem_din
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMem arbiter between CPU memory stage and DMA engine: CPU priority,
// DMA forced after DMA_MAX_WAIT denied cycles, read data routed back with hold registers.
module dmem_arbiter #(
    parameter int AWIDTH       = 14,
    parameter int DWIDTH       = 32,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus_io
);
    localparam logic [3:0] MAX_WAIT = 4'(DMA_MAX_WAIT);

    logic [3:0]        wait_q, wait_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic [DWIDTH-1:0] cpu_hold_q, cpu_hold_d;
    logic [DWIDTH-1:0] dma_hold_q, dma_hold_d;

    logic              cpu_grant, dma_grant;
    logic              cpu_rvalid, dma_rvalid;

    always_comb begin
        dma_grant = ~rst & bus_io.dma_req & (~bus_io.cpu_req | (wait_q == MAX_WAIT));
        cpu_grant = ~rst & bus_io.cpu_req & ~dma_grant;

        // rvalid is suppressed while reset is held, even for a read granted last cycle
        cpu_rvalid = ~rst & rd_pend_q & ~rd_owner_q;
        dma_rvalid = ~rst & rd_pend_q & rd_owner_q;

        if (bus_io.dma_req & ~dma_grant)
            wait_d = (wait_q == MAX_WAIT) ? MAX_WAIT : wait_q + 4'd1;
        else
            wait_d = 4'd0;

        rd_pend_d  = (cpu_grant & (bus_io.cpu_we == 4'd0)) |
                     (dma_grant & (bus_io.dma_we == 4'd0));
        rd_owner_d = dma_grant;

        cpu_hold_d = cpu_rvalid ? bus_io.dmem_dout : cpu_hold_q;
        dma_hold_d = dma_rvalid ? bus_io.dmem_dout : dma_hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q     <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            cpu_hold_q <= '0;
            dma_hold_q <= '0;
        end else begin
            wait_q     <= wait_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            cpu_hold_q <= cpu_hold_d;
            dma_hold_q <= dma_hold_d;
        end
    end

    assign bus_io.cpu_stall  = bus_io.cpu_req & ~cpu_grant & ~rst;
    assign bus_io.dma_gnt    = dma_grant;
    assign bus_io.cpu_rvalid = cpu_rvalid;
    assign bus_io.dma_rvalid = dma_rvalid;
    assign bus_io.cpu_dout   = rst ? '0 : (cpu_rvalid ? bus_io.dmem_dout : cpu_hold_q);
    assign bus_io.dma_dout   = rst ? '0 : (dma_rvalid ? bus_io.dmem_dout : dma_hold_q);

    always_comb begin
        bus_io.dmem_en   = cpu_grant | dma_grant;
        bus_io.dmem_we   = 4'd0;
        bus_io.dmem_addr = '0;
        bus_io.dmem_din  = '0;
        if (dma_grant) begin
            bus_io.dmem_we   = bus_io.dma_we;
            bus_io.dmem_addr = bus_io.dma_addr;
            bus_io.dmem_din  = bus_io.dma_din;
        end else if (cpu_grant) begin
            bus_io.dmem_we   = bus_io.cpu_we;
            bus_io.dmem_addr = bus_io.cpu_addr;
            bus_io.dmem_din  = bus_io.cpu_din;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus constrained-random traffic,
// both compared each cycle against a behavioural model with its own memory image.
module tb_dmem_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    dmem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .DMA_MAX_WAIT(MAXW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    function automatic logic [31:0] init_val(input int i);
        case (i)
            16:      return 32'hDEADBEEF;
            32:      return 32'h11112222;
            48:      return 32'h12345678;
            default: return 32'h5A000000 ^ (32'(i) * 32'h00010203);
        endcase
    endfunction

    // Synchronous single-port memory attached to the DMem side
    logic [31:0] mem [64];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (bus.dmem_en) begin
            if (bus.dmem_we == 4'd0)
                bus.dmem_dout <= mem[bus.dmem_addr[5:0]];
            else
                for (int b = 0; b < 4; b++)
                    if (bus.dmem_we[b]) mem[bus.dmem_addr[5:0]][b*8 +: 8] <= bus.dmem_din[b*8 +: 8];
        end
    end

    typedef struct {
        logic        rst;
        logic        creq;
        logic [3:0]  cwe;
        logic [13:0] caddr;
        logic [31:0] cdin;
        logic        dreq;
        logic [3:0]  dwe;
        logic [13:0] daddr;
        logic [31:0] ddin;
        logic        use_exp;
        logic        e_st, e_gnt, e_en, e_crv;
        logic [31:0] e_cd;
        logic        e_drv;
        logic [31:0] e_dd;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model state
    logic [31:0] ref_mem [64];
    int          m_wait;
    bit          m_pend, m_owner;
    logic [31:0] m_rd, m_chold, m_dhold;
    bit          last_cstall, last_dwait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, creq, input logic [3:0] cwe, input logic [13:0] ca,
                                input logic [31:0] cd, input logic dreq, input logic [3:0] dwe,
                                input logic [13:0] da, input logic [31:0] dd,
                                input logic est, egnt, een, ecrv, input logic [31:0] ecd,
                                input logic edrv, input logic [31:0] edd);
        vec_t v;
        v.rst = r; v.creq = creq; v.cwe = cwe; v.caddr = ca; v.cdin = cd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = da; v.ddin = dd; v.use_exp = 1'b1;
        v.e_st = est; v.e_gnt = egnt; v.e_en = een; v.e_crv = ecrv; v.e_cd = ecd;
        v.e_drv = edrv; v.e_dd = edd;
        return v;
    endfunction

    task automatic step(input vec_t v);
        bit          e_dg, e_cg, e_st, e_en, e_crv, e_drv;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic [31:0] e_din, e_cd, e_dd;
        rst          = v.rst;
        bus.cpu_req  = v.creq;  bus.cpu_we  = v.cwe;  bus.cpu_addr = v.caddr;  bus.cpu_din = v.cdin;
        bus.dma_req  = v.dreq;  bus.dma_we  = v.dwe;  bus.dma_addr = v.daddr;  bus.dma_din = v.ddin;
        @(negedge clk);

        e_dg  = !v.rst && v.dreq && (!v.creq || m_wait == MAXW);
        e_cg  = !v.rst && v.creq && !e_dg;
        e_st  = !v.rst && v.creq && !e_cg;
        e_en  = e_cg || e_dg;
        e_we  = e_dg ? v.dwe   : (e_cg ? v.cwe   : 4'd0);
        e_addr = e_dg ? v.daddr : (e_cg ? v.caddr : 14'd0);
        e_din = e_dg ? v.ddin  : (e_cg ? v.cdin  : 32'd0);
        e_crv = !v.rst && m_pend && !m_owner;
        e_drv = !v.rst && m_pend && m_owner;
        e_cd  = v.rst ? 32'd0 : (e_crv ? m_rd : m_chold);
        e_dd  = v.rst ? 32'd0 : (e_drv ? m_rd : m_dhold);

        chk("cpu_stall",  32'(bus.cpu_stall),  32'(e_st));
        chk("dma_gnt",    32'(bus.dma_gnt),    32'(e_dg));
        chk("dmem_en",    32'(bus.dmem_en),    32'(e_en));
        chk("dmem_we",    32'(bus.dmem_we),    32'(e_we));
        chk("dmem_addr",  32'(bus.dmem_addr),  32'(e_addr));
        chk("dmem_din",   bus.dmem_din,        e_din);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_crv));
        chk("cpu_dout",   bus.cpu_dout,        e_cd);
        chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(e_drv));
        chk("dma_dout",   bus.dma_dout,        e_dd);

        if (v.use_exp) begin
            chk("tbl_cpu_stall",  32'(bus.cpu_stall),  32'(v.e_st));
            chk("tbl_dma_gnt",    32'(bus.dma_gnt),    32'(v.e_gnt));
            chk("tbl_dmem_en",    32'(bus.dmem_en),    32'(v.e_en));
            chk("tbl_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(v.e_crv));
            chk("tbl_cpu_dout",   bus.cpu_dout,        v.e_cd);
            chk("tbl_dma_rvalid", 32'(bus.dma_rvalid), 32'(v.e_drv));
            chk("tbl_dma_dout",   bus.dma_dout,        v.e_dd);
        end

        if (v.rst) begin
            m_wait = 0; m_pend = 0; m_owner = 0; m_chold = 0; m_dhold = 0;
        end else begin
            if (e_crv) m_chold = m_rd;
            if (e_drv) m_dhold = m_rd;
            if (e_en && e_we == 4'd0) m_rd = ref_mem[e_addr[5:0]];
            else if (e_en)
                for (int b = 0; b < 4; b++)
                    if (e_we[b]) ref_mem[e_addr[5:0]][b*8 +: 8] = e_din[b*8 +: 8];
            m_pend  = e_en && (e_we == 4'd0);
            m_owner = e_dg;
            m_wait  = (v.dreq && !e_dg) ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : 0;
        end
        last_cstall = e_st;
        last_dwait  = !v.rst && v.dreq && !e_dg;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    vec_t tbl[$];
    vec_t cur;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        m_wait = 0; m_pend = 0; m_owner = 0; m_rd = 0; m_chold = 0; m_dhold = 0;
        last_cstall = 0; last_dwait = 0;

        //       rst creq cwe  caddr  cdin          dreq dwe  daddr  ddin         st gnt en crv cd            drv dd
        tbl.push_back(mk(1, 1, 4'h0, 'h10, 0,            1, 4'h0, 'h20, 0,            0, 0, 0, 0, 0,            0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,            0, 4'h0, 0,    0,            0, 0, 1, 0, 0,            0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 'h20, 0,            0, 4'h0, 0,    0,            0, 0, 1, 0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            1, 4'hF, 'h20, 32'h33334444, 0, 1, 1, 1, 32'h11112222, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 0, 32'h11112222, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 'h20, 0,            0, 4'h0, 0,    0,            0, 0, 1, 0, 32'h11112222, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 1, 32'h33334444, 0, 0));
        tbl.push_back(mk(0, 1, 4'h4, 'h30, 32'h00AB0000, 0, 4'h0, 0,    0,            0, 0, 1, 0, 32'h33334444, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 'h30, 0,            0, 4'h0, 0,    0,            0, 0, 1, 0, 32'h33334444, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 1, 32'h12AB5678, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            1, 4'h0, 'h10, 0,            0, 1, 1, 0, 32'h12AB5678, 0, 0));
        tbl.push_back(mk(1, 0, 4'h0, 0,    0,            1, 4'h0, 'h10, 0,            0, 0, 0, 0, 0,            0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            1, 4'h0, 'h20, 0,            0, 1, 1, 0, 0,            0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 0, 0,            1, 32'h33334444));
        // Continuous contention: DMA forced every fifth cycle
        tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,            1, 4'h0, 'h30, 0,            0, 0, 1, 0, 0,            0, 32'h33334444));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,        1, 4'h0, 'h30, 0,            0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h33334444));
        tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,            1, 4'h0, 'h30, 0,            1, 1, 1, 1, 32'hDEADBEEF, 0, 32'h33334444));
        tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,            1, 4'h0, 'h30, 0,            0, 0, 1, 0, 32'hDEADBEEF, 1, 32'h12AB5678));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,        1, 4'h0, 'h30, 0,            0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h12AB5678));
        tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,            1, 4'h0, 'h30, 0,            1, 1, 1, 1, 32'hDEADBEEF, 0, 32'h12AB5678));
        // DMA request toggling never accumulates enough wait to be forced
        tbl.push_back(mk(0, 1, 4'h0, 'h10, 0,            0, 4'h0, 0,    0,            0, 0, 1, 0, 32'hDEADBEEF, 1, 32'h12AB5678));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, 4'h0, 'h10, 0, logic'(k % 2 == 0), 4'h0, 'h30, 0,   0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h12AB5678));
        tbl.push_back(mk(0, 0, 4'h0, 0,    0,            0, 4'h0, 0,    0,            0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h12AB5678));

        foreach (tbl[i]) step(tbl[i]);

        // Random traffic; an ungranted request is held unchanged until it wins
        cur = mk(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cur.use_exp = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            cur.rst = ($urandom_range(0, 63) == 0);
            if (!last_cstall) begin
                cur.creq  = ($urandom_range(0, 3) != 0);
                cur.cwe   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                cur.caddr = 14'($urandom_range(0, 15));
                cur.cdin  = $urandom;
            end
            if (!last_dwait) begin
                cur.dreq  = ($urandom_range(0, 2) == 0);
                cur.dwe   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'h0;
                cur.daddr = 14'($urandom_range(0, 15));
                cur.ddin  = $urandom;
            end
            step(cur);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
